reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with an integrated scoreboard, the successor to the processor's fixed 32×32 register bank. It holds 2^ADDR_W registers of DATA_W bits and provides two combinational read ports with write-back bypass. It tracks pending writes per register and gates instruction issue on RAW/WAW hazards. It sits between the instruction decoder (issue side) and the execute/write-back stage (wb side).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREGS = 2^ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_a_addr  in  ADDR_W  read port A index
- rd_a_data  out  DATA_W  read port A data (combinational)
- rd_b_addr  in  ADDR_W  read port B index
- rd_b_data  out  DATA_W  read port B data (combinational)
- issue_valid  in  1  decoder presents an instruction
- issue_dst  in  ADDR_W  destination register of the instruction
- issue_wr  in  1  instruction writes issue_dst
- issue_src_a  in  ADDR_W  first source register
- issue_src_b  in  ADDR_W  second source register
- issue_use_b  in  1  instruction reads issue_src_b (0 for immediate forms)
- issue_ready  out  1  no hazard; the instruction is accepted when issue_valid && issue_ready
- wb_valid  in  1  write-back this cycle
- wb_dst  in  ADDR_W  write-back register index
- wb_data  in  DATA_W  write-back data
- busy_count  out  ADDR_W+1  number of registers with a pending write
- wb_err  out  1  sticky flag: write-back hit a register that was not busy

## Operation
- Storage: NREGS × DATA_W flops, plus busy[NREGS] and the wb_err flop.
- Read: rd_x_data = 0 if ZERO_REG and addr==0. Else wb_data if wb_valid and wb_dst==addr (bypass). Else mem[addr].
- Write: at the clock edge, if wb_valid and not (ZERO_REG and wb_dst==0), mem[wb_dst] <= wb_data.
- Hazard check: src_a is clear if busy[src_a]==0 or (wb_valid and wb_dst==src_a). src_b is checked the same way, and only when issue_use_b=1. dst uses the same rule, and only when issue_wr=1 (WAW).
  - issue_ready = all applicable checks clear.
  - issue_ready is independent of issue_valid.
- Accept: an accepted issue with issue_wr=1 sets busy[issue_dst] at the clock edge.
- Write-back clears busy[wb_dst] at the clock edge.
- Same-edge set and clear of one register: the set wins, so busy stays 1.
- ZERO_REG=1: busy[0] is constantly 0. An issue or write-back to reg 0 has no state effect, and reg 0 never blocks issue.
- Write-back to a register with busy=0 (and not reg 0 under ZERO_REG): data is still written and wb_err is set to 1. wb_err stays 1 until reset.
- busy_count is the registered population count of busy, updated in the same cycle as busy.

## Timing
- Reset (rst_n=0, immediate, independent of clk):
  - all registers, busy and wb_err are cleared to 0
  - busy_count=0
  - issue_ready=1 for any inputs
  - read data is 0 unless bypassed from wb
- Reset is released synchronously to clk by the top level; the first edge after release is a normal cycle.
- Read latency 0 (combinational). Written data is visible from mem on the cycle after the edge, and via bypass in the write cycle itself.
- Issue-to-busy latency 1 edge. A dependent instruction presented in the cycle after the producer's issue sees issue_ready=0.
- Write-back releases a stalled consumer in the same cycle, via the bypass term.
- Reset mid-operation discards all pending writes. A write-back arriving after reset for a pre-reset issue sets wb_err.
- Read, issue_ready and bypass paths are combinational; no combinational loop from issue_valid to issue_ready.

## Test plan
- Reset then read: assert rst_n=0 mid-cycle with regs holding data. Required: rd_a_data=0 and rd_b_data=0 for all addrs, busy_count=0, wb_err=0, all immediately without a clock edge.
- Write/bypass: wb_valid=1, wb_dst=5, wb_data=0xDEADBEEF, rd_a_addr=5. Required: rd_a_data=0xDEADBEEF in the same cycle, and after the edge with wb_valid=0.
- Zero register (ZERO_REG=1): wb_dst=0, wb_data=0x1234. Required: rd_a_data of reg 0 is 0 before and after, busy_count unchanged, wb_err=0.
- RAW stall/release: issue dst=3 (accepted), then issue src_a=3. Required: issue_ready=0 and busy_count=1. When wb_valid=1 with wb_dst=3 in a later cycle, required: issue_ready=1 in that same cycle and busy_count=0 after the edge.
- Simultaneous set/clear: reg 7 busy; in one cycle accept an issue with dst=7 and wb_dst=7. Required: busy[7] still 1 (a following issue with src_a=7 sees issue_ready=0), busy_count stays 1.
- Spurious write-back and WAW: wb to non-busy reg 9. Required: wb_err=1 from the next cycle until reset. Issue dst=9 while reg 9 is busy and no wb. Required: issue_ready=0.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Issue, write-back and read-port bundle between decoder, execute/write-back
// and the scoreboarded register file.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_src_a;
    logic [ADDR_W-1:0] issue_src_b;
    logic              issue_use_b;
    logic              issue_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W:0]   busy_count;
    logic              wb_err;

    modport master (
        output rd_a_addr, rd_b_addr, issue_valid, issue_dst, issue_wr,
               issue_src_a, issue_src_b, issue_use_b, wb_valid, wb_dst, wb_data,
        input  rd_a_data, rd_b_data, issue_ready, busy_count, wb_err
    );

    modport slave (
        input  rd_a_addr, rd_b_addr, issue_valid, issue_dst, issue_wr,
               issue_src_a, issue_src_b, issue_use_b, wb_valid, wb_dst, wb_data,
        output rd_a_data, rd_b_data, issue_ready, busy_count, wb_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-back bypass and a per-register pending-write
// scoreboard that holds issue on RAW/WAW hazards.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] mem;
    logic [NREGS-1:0]             busy;
    logic [NREGS-1:0]             busy_nxt;
    logic [ADDR_W:0]              cnt_q;
    logic [ADDR_W:0]              cnt_nxt;
    logic                         err_q;
    logic                         wb_zero;
    logic                         wb_we;
    logic                         wb_spur;
    logic                         clr_a;
    logic                         clr_b;
    logic                         clr_d;
    logic                         accept;

    // Reg 0 under ZERO_REG is hardwired: no reads, writes or hazards.
    assign wb_zero = ZERO_REG && (bus.wb_dst == '0);
    assign wb_we   = bus.wb_valid && !wb_zero;
    assign wb_spur = wb_we && !busy[bus.wb_dst];

    always_comb begin
        if (ZERO_REG && bus.rd_a_addr == '0)
            bus.rd_a_data = '0;
        else if (bus.wb_valid && bus.wb_dst == bus.rd_a_addr)
            bus.rd_a_data = bus.wb_data;
        else
            bus.rd_a_data = mem[bus.rd_a_addr];
    end

    always_comb begin
        if (ZERO_REG && bus.rd_b_addr == '0)
            bus.rd_b_data = '0;
        else if (bus.wb_valid && bus.wb_dst == bus.rd_b_addr)
            bus.rd_b_data = bus.wb_data;
        else
            bus.rd_b_data = mem[bus.rd_b_addr];
    end

    // A write-back landing this cycle clears the hazard it would resolve.
    assign clr_a = !busy[bus.issue_src_a] || (bus.wb_valid && bus.wb_dst == bus.issue_src_a);
    assign clr_b = !busy[bus.issue_src_b] || (bus.wb_valid && bus.wb_dst == bus.issue_src_b);
    assign clr_d = !busy[bus.issue_dst]   || (bus.wb_valid && bus.wb_dst == bus.issue_dst);

    assign bus.issue_ready = clr_a && (!bus.issue_use_b || clr_b) && (!bus.issue_wr || clr_d);
    assign accept          = bus.issue_valid && bus.issue_ready;

    // Clear before set so a same-edge issue to the same register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_valid)
            busy_nxt[bus.wb_dst] = 1'b0;
        if (accept && bus.issue_wr)
            busy_nxt[bus.issue_dst] = 1'b1;
        if (ZERO_REG)
            busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            busy  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (wb_we)
                mem[bus.wb_dst] <= bus.wb_data;
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
            if (wb_spur)
                err_q <= 1'b1;
        end
    end

    assign bus.busy_count = cnt_q;
    assign bus.wb_err     = err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against a behavioural
// array model of registers, pending writes and the error flag.
module tb_reg_file_sb;
    logic clk;
    logic rst_n;
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 0;

    logic [31:0] m_mem [32];
    bit          m_busy[32];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 0;
        end
        m_err = 0;
    endfunction

    function automatic bit m_clear(input logic [4:0] r);
        return !m_busy[r] || (bus.wb_valid && bus.wb_dst == r);
    endfunction

    function automatic bit m_ready();
        return m_clear(bus.issue_src_a) && (!bus.issue_use_b || m_clear(bus.issue_src_b))
            && (!bus.issue_wr || m_clear(bus.issue_dst));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.wb_valid && bus.wb_dst == a) return bus.wb_data;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 32'(c);
    endfunction

    // One edge of the architectural rules, applied to the inputs held this cycle.
    function automatic void m_edge();
        bit rdy = m_ready();
        if (bus.wb_valid && bus.wb_dst != 0) begin
            m_mem[bus.wb_dst] = bus.wb_data;
            if (!m_busy[bus.wb_dst]) m_err = 1;
            m_busy[bus.wb_dst] = 0;
        end
        if (bus.issue_valid && rdy && bus.issue_wr && bus.issue_dst != 0)
            m_busy[bus.issue_dst] = 1;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("rd_a_data", bus.rd_a_data, m_read(bus.rd_a_addr));
            chk("rd_b_data", bus.rd_b_data, m_read(bus.rd_b_addr));
            chk("issue_ready", 32'(bus.issue_ready), 32'(m_ready()));
            chk("busy_count", 32'(bus.busy_count), m_count());
            chk("wb_err", 32'(bus.wb_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic idle();
        bus.rd_a_addr = '0;  bus.rd_b_addr = '0;
        bus.issue_valid = 0; bus.issue_dst = '0; bus.issue_wr = 0;
        bus.issue_src_a = '0; bus.issue_src_b = '0; bus.issue_use_b = 0;
        bus.wb_valid = 0; bus.wb_dst = '0; bus.wb_data = '0;
    endtask

    task automatic issue(input logic [4:0] dst, input bit wr, input logic [4:0] sa);
        bus.issue_valid = 1; bus.issue_dst = dst; bus.issue_wr = wr;
        bus.issue_src_a = sa; bus.issue_src_b = '0; bus.issue_use_b = 0;
    endtask

    task automatic wb(input logic [4:0] dst, input logic [31:0] d);
        bus.wb_valid = 1; bus.wb_dst = dst; bus.wb_data = d;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_reset();
        run = 1;
        repeat (2) tick();
        rst_n = 1;
        #1;
        chk("rst_cnt", 32'(bus.busy_count), 32'd0);
        chk("rst_err", 32'(bus.wb_err), 32'd0);
        chk("rst_ready", 32'(bus.issue_ready), 32'd1);
        tick();

        // zero register: write ignored, no busy, no error
        idle(); wb(5'd0, 32'h1234); bus.rd_a_addr = 5'd0; #1;
        chk("zero_rd_wb", bus.rd_a_data, 32'h0);
        tick(); idle(); #1;
        chk("zero_rd_after", bus.rd_a_data, 32'h0);
        chk("zero_cnt", 32'(bus.busy_count), 32'd0);
        chk("zero_err", 32'(bus.wb_err), 32'd0);
        tick();

        // RAW stall and same-cycle release through the bypass
        idle(); issue(5'd3, 1, 5'd1); #1;
        chk("raw_prod_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        idle(); issue(5'd4, 0, 5'd3); #1;
        chk("raw_stall", 32'(bus.issue_ready), 32'd0);
        chk("raw_cnt1", 32'(bus.busy_count), 32'd1);
        chk("raw_mdl_cnt1", m_count(), 32'd1);
        tick();
        chk("raw_still_stall", 32'(bus.issue_ready), 32'd0);
        wb(5'd3, 32'h0000_0033); bus.rd_a_addr = 5'd3; #1;
        chk("raw_release", 32'(bus.issue_ready), 32'd1);
        chk("raw_bypass", bus.rd_a_data, 32'h33);
        tick(); idle(); bus.rd_a_addr = 5'd3; #1;
        chk("raw_cnt0", 32'(bus.busy_count), 32'd0);
        chk("raw_mem", bus.rd_a_data, 32'h33);
        tick();

        // same-edge set and clear of reg 7: set wins
        idle(); issue(5'd7, 1, 5'd0); tick();
        idle(); issue(5'd7, 1, 5'd0); wb(5'd7, 32'h77); #1;
        chk("sim_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        idle(); issue(5'd8, 0, 5'd7); #1;
        chk("sim_stall", 32'(bus.issue_ready), 32'd0);
        chk("sim_cnt", 32'(bus.busy_count), 32'd1);
        chk("sim_err", 32'(bus.wb_err), 32'd0);
        tick();
        idle(); wb(5'd7, 32'h78); tick();

        // legal write to reg 5, then bypass and stored value
        idle(); issue(5'd5, 1, 5'd0); tick();
        idle(); wb(5'd5, 32'hDEADBEEF); bus.rd_a_addr = 5'd5; #1;
        chk("wb_bypass", bus.rd_a_data, 32'hDEADBEEF);
        tick(); idle(); bus.rd_a_addr = 5'd5; #1;
        chk("wb_mem", bus.rd_a_data, 32'hDEADBEEF);
        chk("wb_err_clean", 32'(bus.wb_err), 32'd0);
        tick();

        // spurious write-back to reg 9, then WAW on reg 9
        idle(); wb(5'd9, 32'h99); #1;
        chk("spur_err_pre", 32'(bus.wb_err), 32'd0);
        tick(); idle(); #1;
        chk("spur_err_post", 32'(bus.wb_err), 32'd1);
        issue(5'd9, 1, 5'd0); tick();
        idle(); issue(5'd9, 1, 5'd0); #1;
        chk("waw_stall", 32'(bus.issue_ready), 32'd0);
        bus.issue_wr = 0; #1;
        chk("waw_nowr_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        idle(); issue(5'd6, 1, 5'd0); tick();
        chk("err_sticky", 32'(bus.wb_err), 32'd1);

        // asynchronous reset mid-cycle with reg 6 and reg 9 pending
        idle(); bus.rd_a_addr = 5'd5; bus.rd_b_addr = 5'd3; issue(5'd6, 0, 5'd6); #2;
        rst_n = 0; m_reset(); #1;
        chk("arst_rd_a", bus.rd_a_data, 32'h0);
        chk("arst_rd_b", bus.rd_b_data, 32'h0);
        chk("arst_cnt", 32'(bus.busy_count), 32'd0);
        chk("arst_err", 32'(bus.wb_err), 32'd0);
        chk("arst_ready", 32'(bus.issue_ready), 32'd1);
        tick(); tick();
        rst_n = 1; idle(); wb(5'd6, 32'h66); tick();
        idle(); #1;
        chk("post_rst_err", 32'(bus.wb_err), 32'd1);
        tick();

        // randomised traffic on a small register window to force collisions
        for (int c = 0; c < 600; c++) begin
            bus.rd_a_addr   = 5'($urandom_range(0, 7));
            bus.rd_b_addr   = 5'($urandom_range(0, 31));
            bus.issue_valid = ($urandom_range(0, 3) != 0);
            bus.issue_dst   = 5'($urandom_range(0, 7));
            bus.issue_wr    = ($urandom_range(0, 3) != 0);
            bus.issue_src_a = 5'($urandom_range(0, 7));
            bus.issue_src_b = 5'($urandom_range(0, 7));
            bus.issue_use_b = $urandom_range(0, 1) == 1;
            bus.wb_valid    = ($urandom_range(0, 9) < 4);
            bus.wb_dst      = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            tick();
        end

        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
